// File: rtl/match_control_fsm_if.sv
// Match-control signal bundle: player/game requests in, serve pulses, visibility and score out.
// master drives the requests and observes the status; slave is the FSM side.
interface match_control_fsm_if #(
    parameter int SCORE_W = 4
);
    logic               serve;
    logic               miss_l;
    logic               miss_r;
    logic               new_game;
    logic               srv_l;
    logic               srv_r;
    logic               visible;
    logic [SCORE_W-1:0] score_l;
    logic [SCORE_W-1:0] score_r;
    logic               game_over;
    logic               winner;

    modport master (
        output serve, miss_l, miss_r, new_game,
        input  srv_l, srv_r, visible, score_l, score_r, game_over, winner
    );

    modport slave (
        input  serve, miss_l, miss_r, new_game,
        output srv_l, srv_r, visible, score_l, score_r, game_over, winner
    );
endinterface

// File: rtl/match_control_fsm.sv
// Pong-style match sequencer: serve, rally, point hold, game over; scores and serve pulses.
// All outputs registered (one-cycle response to inputs); no backpressure, inputs level-sampled.
module match_control_fsm #(
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 11,
    parameter int POINT_HOLD  = 60,
    parameter int SERVE_DELAY = 0
) (
    input logic               clk,
    input logic               reset,
    match_control_fsm_if.slave bus
);
    localparam int CNT_MAX = (SERVE_DELAY > POINT_HOLD) ? SERVE_DELAY : POINT_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam bit AUTO_SERVE = (SERVE_DELAY > 0);
    localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(POINT_HOLD - 1);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'((SERVE_DELAY > 0) ? SERVE_DELAY - 1 : 0);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

    typedef enum logic [1:0] {WAIT_SERVE, PLAY, POINT, OVER} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               server_l_q, server_l_d;
    logic               srv_l_q, srv_l_d;
    logic               srv_r_q, srv_r_d;
    logic               visible_q, visible_d;
    logic               game_over_q, game_over_d;
    logic               winner_q, winner_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d;
    logic [SCORE_W-1:0] score_r_q, score_r_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        server_l_d  = server_l_q;
        srv_l_d     = 1'b0;
        srv_r_d     = 1'b0;
        visible_d   = visible_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;

        if (bus.new_game) begin
            state_d     = WAIT_SERVE;
            cnt_d       = '0;
            server_l_d  = 1'b1;
            visible_d   = 1'b0;
            game_over_d = 1'b0;
            winner_d    = 1'b0;
            score_l_d   = '0;
            score_r_d   = '0;
        end else begin
            case (state_q)
                WAIT_SERVE: begin
                    visible_d = 1'b0;
                    if (bus.serve || (AUTO_SERVE && cnt_q == SERVE_LAST)) begin
                        state_d   = PLAY;
                        cnt_d     = '0;
                        visible_d = 1'b1;
                        srv_l_d   = server_l_q;
                        srv_r_d   = !server_l_q;
                    end else if (AUTO_SERVE) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PLAY: begin
                    // A simultaneous double miss is a replay: no score, same server.
                    if (bus.miss_l || bus.miss_r) begin
                        state_d   = POINT;
                        cnt_d     = '0;
                        visible_d = 1'b0;
                        if (bus.miss_l && !bus.miss_r) begin
                            server_l_d = 1'b1;
                            if (score_r_q != WIN) score_r_d = score_r_q + 1'b1;
                        end else if (bus.miss_r && !bus.miss_l) begin
                            server_l_d = 1'b0;
                            if (score_l_q != WIN) score_l_d = score_l_q + 1'b1;
                        end
                    end
                end
                POINT: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d = '0;
                        if (score_l_q == WIN || score_r_q == WIN) begin
                            state_d     = OVER;
                            game_over_d = 1'b1;
                            winner_d    = (score_l_q == WIN);
                        end else begin
                            state_d = WAIT_SERVE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                OVER: begin
                    visible_d = 1'b0;
                end
                default: begin
                    state_d = WAIT_SERVE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= WAIT_SERVE;
            cnt_q       <= '0;
            server_l_q  <= 1'b1;
            srv_l_q     <= 1'b0;
            srv_r_q     <= 1'b0;
            visible_q   <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
            score_l_q   <= '0;
            score_r_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            server_l_q  <= server_l_d;
            srv_l_q     <= srv_l_d;
            srv_r_q     <= srv_r_d;
            visible_q   <= visible_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
        end
    end

    assign bus.srv_l     = srv_l_q;
    assign bus.srv_r     = srv_r_q;
    assign bus.visible   = visible_q;
    assign bus.game_over = game_over_q;
    assign bus.winner    = winner_q;
    assign bus.score_l   = score_l_q;
    assign bus.score_r   = score_r_q;
endmodule

// File: tb/tb_match_control_fsm.sv
// Directed bench: manual-serve instance (WIN=3, HOLD=2) plus an auto-serve instance (SERVE_DELAY=5).
module tb_match_control_fsm;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    match_control_fsm_if #(.SCORE_W(4)) b ();
    match_control_fsm_if #(.SCORE_W(4)) bd ();

    match_control_fsm #(.SCORE_W(4), .WIN_SCORE(3), .POINT_HOLD(2), .SERVE_DELAY(0)) dut (
        .clk(clk), .reset(reset), .bus(b)
    );
    match_control_fsm #(.SCORE_W(4), .WIN_SCORE(3), .POINT_HOLD(2), .SERVE_DELAY(5)) dut_d (
        .clk(clk), .reset(reset), .bus(bd)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [12:0] obs, obs_d, exp_v;

    // {srv_l, srv_r, visible, game_over, winner, score_l, score_r}
    assign obs   = {b.srv_l, b.srv_r, b.visible, b.game_over, b.winner, b.score_l, b.score_r};
    assign obs_d = {bd.srv_l, bd.srv_r, bd.visible, bd.game_over, bd.winner, bd.score_l, bd.score_r};

    function automatic logic [12:0] pack(input logic sl, input logic sr, input logic vis,
                                         input logic go, input logic win, input int scl, input int scr);
        return {sl, sr, vis, go, win, 4'(scl), 4'(scr)};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        b.serve = 0; b.miss_l = 0; b.miss_r = 0; b.new_game = 0;
        bd.serve = 0; bd.miss_l = 0; bd.miss_r = 0; bd.new_game = 0;
        #2 reset = 1'b0;
        #1;
        exp_v = pack(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL reset_async: got %b want %b", obs, exp_v); end
        vectors++;
        if (obs_d !== exp_v) begin miscompares++; $display("FAIL reset_async_d: got %b want %b", obs_d, exp_v); end
        step(2);
        reset = 1'b1;
        step(1);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL idle_after_reset: got %b want %b", obs, exp_v); end
    endtask

    task automatic test_serve;
        b.serve = 1;
        step(1);
        exp_v = pack(1, 0, 1, 0, 0, 0, 0);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL serve_left: got %b want %b", obs, exp_v); end
        b.serve = 0;
        step(1);
        exp_v = pack(0, 0, 1, 0, 0, 0, 0);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL srv_one_cycle: got %b want %b", obs, exp_v); end
    endtask

    // serve held across POINT: a pulse exactly three edges after the miss proves a 2-cycle hold
    task automatic test_point_right_miss;
        b.miss_r = 1;
        step(1);
        exp_v = pack(0, 0, 0, 0, 0, 1, 0);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL point_score_l: got %b want %b", obs, exp_v); end
        b.miss_r = 0;
        b.serve = 1;
        step(1);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL point_hold1: got %b want %b", obs, exp_v); end
        step(1);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL point_hold2: got %b want %b", obs, exp_v); end
        step(1);
        exp_v = pack(0, 1, 1, 0, 0, 1, 0);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL serve_right: got %b want %b", obs, exp_v); end
        step(1);
        exp_v = pack(0, 0, 1, 0, 0, 1, 0);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL serve_held_no_repeat: got %b want %b", obs, exp_v); end
        b.serve = 0;
    endtask

    task automatic test_double_miss;
        b.miss_l = 1; b.miss_r = 1;
        step(1);
        exp_v = pack(0, 0, 0, 0, 0, 1, 0);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL replay_scores: got %b want %b", obs, exp_v); end
        b.miss_l = 0; b.miss_r = 0;
        b.serve = 1;
        step(2);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL replay_hold: got %b want %b", obs, exp_v); end
        step(1);
        exp_v = pack(0, 1, 1, 0, 0, 1, 0);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL replay_server: got %b want %b", obs, exp_v); end
        b.serve = 0;
    endtask

    task automatic test_win;
        b.miss_r = 1;
        step(1);
        b.miss_r = 0;
        exp_v = pack(0, 0, 0, 0, 0, 2, 0);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL score_l_2: got %b want %b", obs, exp_v); end
        b.serve = 1;
        step(3);
        b.serve = 0;
        exp_v = pack(0, 1, 1, 0, 0, 2, 0);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL serve_r_again: got %b want %b", obs, exp_v); end
        b.miss_r = 1;
        step(1);
        b.miss_r = 0;
        step(2);
        exp_v = pack(0, 0, 0, 1, 1, 3, 0);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL game_over: got %b want %b", obs, exp_v); end
        b.serve = 1; b.miss_l = 1; b.miss_r = 1;
        step(3);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL over_frozen: got %b want %b", obs, exp_v); end
        b.serve = 0; b.miss_l = 0; b.miss_r = 0;
        b.new_game = 1;
        step(1);
        b.new_game = 0;
        exp_v = pack(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL new_game_clear: got %b want %b", obs, exp_v); end
        b.serve = 1;
        step(1);
        b.serve = 0;
        exp_v = pack(1, 0, 1, 0, 0, 0, 0);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL new_game_serve_l: got %b want %b", obs, exp_v); end
    endtask

    task automatic test_new_game_priority;
        b.miss_r = 1; b.new_game = 1; b.serve = 1;
        step(1);
        b.miss_r = 0;
        exp_v = pack(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL ng_over_miss: got %b want %b", obs, exp_v); end
        step(1);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL ng_suppress_srv: got %b want %b", obs, exp_v); end
        b.new_game = 0;
        step(1);
        b.serve = 0;
        exp_v = pack(1, 0, 1, 0, 0, 0, 0);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL ng_then_serve: got %b want %b", obs, exp_v); end
    endtask

    task automatic test_reset_mid_play;
        b.miss_r = 1;
        step(1);
        b.miss_r = 0;
        b.serve = 1;
        step(3);
        b.serve = 0;
        exp_v = pack(0, 1, 1, 0, 0, 1, 0);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL rst_setup: got %b want %b", obs, exp_v); end
        b.miss_l = 1;
        #2 reset = 1'b0;
        #1;
        exp_v = pack(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL async_reset_mid_play: got %b want %b", obs, exp_v); end
        step(1);
        b.miss_l = 0;
        reset = 1'b1;
        step(1);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL no_score_after_release: got %b want %b", obs, exp_v); end
        b.serve = 1;
        step(1);
        b.serve = 0;
        exp_v = pack(1, 0, 1, 0, 0, 0, 0);
        vectors++;
        if (obs !== exp_v) begin miscompares++; $display("FAIL server_l_after_reset: got %b want %b", obs, exp_v); end
    endtask

    task automatic test_auto_serve;
        bd.new_game = 1;
        step(1);
        bd.new_game = 0;
        exp_v = pack(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (obs_d !== exp_v) begin miscompares++; $display("FAIL auto_entry: got %b want %b", obs_d, exp_v); end
        step(4);
        vectors++;
        if (obs_d !== exp_v) begin miscompares++; $display("FAIL auto_wait4: got %b want %b", obs_d, exp_v); end
        step(1);
        exp_v = pack(1, 0, 1, 0, 0, 0, 0);
        vectors++;
        if (obs_d !== exp_v) begin miscompares++; $display("FAIL auto_serve_5: got %b want %b", obs_d, exp_v); end
        bd.serve = 1;
        step(3);
        exp_v = pack(0, 0, 1, 0, 0, 0, 0);
        vectors++;
        if (obs_d !== exp_v) begin miscompares++; $display("FAIL no_second_srv: got %b want %b", obs_d, exp_v); end
        bd.serve = 0;
    endtask

    initial begin
        test_reset();
        test_serve();
        test_point_right_miss();
        test_double_miss();
        test_win();
        test_new_game_priority();
        test_reset_mid_play();
        test_auto_serve();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/match_control_fsm.md
MATCH_CONTROL_FSM -- requirements
Module: match_control_fsm

Interface
REQ-001 The block SHALL have parameter SCORE_W, default 4: width of each score counter.
REQ-002 The block SHALL have parameter WIN_SCORE, default 11: points needed to win; legal range 1 to 2^SCORE_W-1.
REQ-003 The block SHALL have parameter POINT_HOLD, default 60: cycles the ball stays hidden after a point; legal range 1 or more.
REQ-004 The block SHALL have parameter SERVE_DELAY, default 0: auto-serve after this many WAIT_SERVE cycles; 0 means manual serve only.
REQ-005 Port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset (0 = reset).
REQ-007 Port serve, input, 1: serve request, level-sampled.
REQ-008 Port miss_l, input, 1: left player missed the ball.
REQ-009 Port miss_r, input, 1: right player missed the ball.
REQ-010 Port new_game, input, 1: synchronous restart request.
REQ-011 Port srv_l, output, 1: one-cycle pulse; ball launched by the left player.
REQ-012 Port srv_r, output, 1: one-cycle pulse; ball launched by the right player.
REQ-013 Port visible, output, 1: ball shown.
REQ-014 Port score_l, output, SCORE_W: left player's score.
REQ-015 Port score_r, output, SCORE_W: right player's score.
REQ-016 Port game_over, output, 1: match finished.
REQ-017 Port winner, output, 1: 1 = left won, 0 = right won; valid only while game_over=1.

Function
REQ-018 States SHALL be WAIT_SERVE, PLAY, POINT and OVER.
REQ-019 All outputs SHALL be registered, and an internal server flag (L/R) SHALL select the serving player.
REQ-020 In WAIT_SERVE: visible=0; counter dly counts cycles spent in the state.
REQ-021 WAIT_SERVE -> PLAY on serve=1, or on dly==SERVE_DELAY-1 when SERVE_DELAY>0, whichever comes first.
REQ-022 On the WAIT_SERVE -> PLAY transition, srv_l (server=L) or srv_r (server=R) SHALL be high for exactly the first PLAY cycle, never both.
REQ-023 In PLAY: visible=1; serve is ignored; holding serve high never produces a second srv pulse.
REQ-024 PLAY with miss_l=1 and miss_r=0: score_r+1, server=L, go to POINT.
REQ-025 PLAY with miss_r=1 and miss_l=0: score_l+1, server=R, go to POINT.
REQ-026 PLAY with miss_l=1 and miss_r=1 in the same cycle: no score change, server unchanged, go to POINT (replay).
REQ-027 In POINT: visible=0; misses and serve are ignored; the state lasts exactly POINT_HOLD cycles.
REQ-028 Leaving POINT: go to OVER if score_l==WIN_SCORE or score_r==WIN_SCORE, otherwise go to WAIT_SERVE with dly=0.
REQ-029 In OVER: game_over=1; visible=0; winner=(score_l==WIN_SCORE); scores are held.
REQ-030 Scores SHALL never exceed WIN_SCORE and SHALL never wrap.
REQ-031 new_game=1 in any state SHALL have highest priority and take effect on the next edge: scores=0, server=L, game_over=0, srv pulses suppressed, dly=0, state=WAIT_SERVE.
REQ-032 miss_l and miss_r SHALL be ignored in WAIT_SERVE and OVER.
REQ-033 Only one point can be scored per PLAY entry.

Reset
REQ-034 While reset=0, outputs SHALL immediately be: srv_l=0, srv_r=0, visible=0, score_l=0, score_r=0, game_over=0, winner=0.
REQ-035 While reset=0, state=WAIT_SERVE, server=L and dly=0.
REQ-036 Reset asserted mid-PLAY or mid-POINT SHALL abandon the rally; no score update SHALL occur on reset release.
REQ-037 After reset is released, the first state change SHALL occur on a rising clk edge.

Verification (WIN_SCORE=3, POINT_HOLD=2, SERVE_DELAY=0 unless stated)
REQ-038 Reset, then serve=1 for one cycle -> srv_l=1 for exactly one cycle, visible=1, srv_r=0.
REQ-039 In PLAY, miss_r=1 for one cycle -> score_l=1, visible=0 for 2 cycles, then WAIT_SERVE; next serve -> srv_r pulse.
REQ-040 In PLAY, miss_l=1 and miss_r=1 together -> scores unchanged, server unchanged, POINT then WAIT_SERVE.
REQ-041 Left scores 3 points -> game_over=1, winner=1, score_l=3; a further serve or miss changes nothing; new_game -> scores 0, srv_l on the next serve.
REQ-042 SERVE_DELAY=5, serve held 0 -> srv pulse 5 cycles after WAIT_SERVE entry; holding serve=1 through PLAY gives no second pulse.
REQ-043 reset=0 pulsed mid-PLAY between clock edges -> outputs reach reset values without a clock edge; score unchanged by any pending miss.
